// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one single-port synchronous RAM between pipeline requesters.
// Lock-aware fixed/round-robin grant, RAM mux, and a latency-matched read-response pipe.
module mem_port_arbiter #(
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned RR_MODE     = 1,
    parameter int unsigned MAX_LOCK    = 4
) (
    input  logic                         gclk,
    input  logic                         PowerOn,
    input  logic [NUM_CH-1:0]            ReqValid,
    input  logic [NUM_CH-1:0]            ReqWrite,
    input  logic [NUM_CH-1:0]            ReqLock,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ReqAddr,
    input  logic [NUM_CH*WORD_WIDTH-1:0] ReqWData,
    output logic [NUM_CH-1:0]            ReqGrant,
    output logic [NUM_CH-1:0]            Stall,
    output logic [NUM_CH-1:0]            RespValid,
    output logic [WORD_WIDTH-1:0]        RespData,
    output logic                         RamEn,
    output logic                         RamWrite,
    output logic [ADDR_WIDTH-1:0]        RamAddr,
    output logic [WORD_WIDTH-1:0]        RamWData,
    input  logic [WORD_WIDTH-1:0]        RamRData
);

    localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = 4;

    logic [ID_W-1:0]                  r_ptr;
    logic                             r_lock_vld;
    logic [ID_W-1:0]                  r_lock_own;
    logic [CNT_W-1:0]                 r_lock_cnt;
    logic [RAM_LATENCY-1:0]           r_pipe_vld;
    logic [RAM_LATENCY-1:0][ID_W-1:0] r_pipe_id;

    logic [NUM_CH-1:0]     w_above;
    logic [NUM_CH-1:0]     w_pick;
    logic [NUM_CH-1:0]     w_grant;
    logic                  w_lock_hit;
    logic                  w_ext;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WORD_WIDTH-1:0] w_wdata;
    logic                  w_write;

    // Lock owner first; otherwise lowest requester at/above the pointer, falling back to lowest overall.
    always_comb begin
        w_grant    = '0;
        w_ext      = 1'b0;
        w_lock_hit = r_lock_vld && ReqValid[r_lock_own] && (r_lock_cnt < CNT_W'(MAX_LOCK));
        w_above    = ~((NUM_CH'(1) << r_ptr) - NUM_CH'(1));
        w_pick     = ReqValid;
        if ((RR_MODE != 0) && ((ReqValid & w_above) != '0)) begin
            w_pick = ReqValid & w_above;
        end
        if (PowerOn) begin
            if (w_lock_hit) begin
                w_grant = NUM_CH'(1) << r_lock_own;
                w_ext   = 1'b1;
            end else begin
                w_grant = w_pick & (~w_pick + NUM_CH'(1));
            end
        end
    end

    // Route the granted channel onto the RAM port; all zeros when idle.
    always_comb begin
        w_gnt_id = '0;
        w_addr   = '0;
        w_wdata  = '0;
        w_write  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_gnt_id = ID_W'(i);
                w_addr   = ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata  = ReqWData[i*WORD_WIDTH +: WORD_WIDTH];
                w_write  = ReqWrite[i];
            end
        end
    end

    assign ReqGrant = w_grant;
    assign Stall    = ReqValid & ~w_grant;
    assign RamEn    = |w_grant;
    assign RamWrite = w_write;
    assign RamAddr  = w_addr;
    assign RamWData = w_wdata;

    // Counter counts lock-extended grants; the pointer only moves on priority-decided grants.
    always_ff @(posedge gclk or negedge PowerOn) begin
        if (!PowerOn) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
            r_lock_cnt <= '0;
        end else if (RamEn) begin
            if (!w_ext) begin
                r_ptr <= (w_gnt_id == ID_W'(NUM_CH - 1)) ? '0 : w_gnt_id + ID_W'(1);
            end
            r_lock_vld <= ReqLock[w_gnt_id];
            r_lock_own <= w_gnt_id;
            if (!ReqLock[w_gnt_id] || !w_ext) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != CNT_W'(MAX_LOCK)) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
        end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= '0;
        end
    end

    // Read tags ride alongside the RAM latency and retire as a one-cycle response.
    always_ff @(posedge gclk or negedge PowerOn) begin
        if (!PowerOn) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
            RespValid  <= '0;
            RespData   <= '0;
        end else begin
            r_pipe_vld[0] <= RamEn & ~RamWrite;
            r_pipe_id[0]  <= w_gnt_id;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
            RespValid <= r_pipe_vld[RAM_LATENCY-1] ? (NUM_CH'(1) << r_pipe_id[RAM_LATENCY-1]) : '0;
            if (r_pipe_vld[RAM_LATENCY-1]) begin
                RespData <= RamRData;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each against its own RAM and a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int NCH = 3;
    localparam int LAT = 2;
    localparam int ML  = 4;

    logic        gclk;
    logic        PowerOn;
    logic [2:0]  rv, rw, rl;
    logic [15:0] ra [3];
    logic [15:0] rd [3];
    logic [47:0] addr_bus, wd_bus;

    logic [2:0]  gnt [2];
    logic [2:0]  stall [2];
    logic [2:0]  rvalid [2];
    logic [15:0] rdata [2];
    logic [15:0] ram_addr [2];
    logic [15:0] ram_wd [2];
    logic [15:0] ram_rd [2];
    logic        ram_en [2];
    logic        ram_we [2];

    assign addr_bus = {ra[2], ra[1], ra[0]};
    assign wd_bus   = {rd[2], rd[1], rd[0]};

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 16'h00A1;
            8'h20:   return 16'h00B2;
            8'h30:   return 16'h00C3;
            default: return {8'h50, a};
        endcase
    endfunction

    // Instance 0 is round-robin, instance 1 fixed priority; each has a write-first RAM of latency LAT.
    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [15:0]  mem [256];
        logic [255:0] wmask;
        logic [15:0]  rpipe [LAT];

        mem_port_arbiter #(
            .WORD_WIDTH (16),
            .ADDR_WIDTH (16),
            .NUM_CH     (NCH),
            .RAM_LATENCY(LAT),
            .RR_MODE    ((k == 0) ? 1 : 0),
            .MAX_LOCK   (ML)
        ) u_dut (
            .gclk     (gclk),
            .PowerOn  (PowerOn),
            .ReqValid (rv),
            .ReqWrite (rw),
            .ReqLock  (rl),
            .ReqAddr  (addr_bus),
            .ReqWData (wd_bus),
            .ReqGrant (gnt[k]),
            .Stall    (stall[k]),
            .RespValid(rvalid[k]),
            .RespData (rdata[k]),
            .RamEn    (ram_en[k]),
            .RamWrite (ram_we[k]),
            .RamAddr  (ram_addr[k]),
            .RamWData (ram_wd[k]),
            .RamRData (ram_rd[k])
        );

        always @(posedge gclk) begin
            if (!PowerOn) begin
                wmask <= '0;
            end else if (ram_en[k] && ram_we[k]) begin
                mem[ram_addr[k][7:0]]   <= ram_wd[k];
                wmask[ram_addr[k][7:0]] <= 1'b1;
            end
            if (ram_en[k] && !ram_we[k]) begin
                rpipe[0] <= wmask[ram_addr[k][7:0]] ? mem[ram_addr[k][7:0]] : init_val(ram_addr[k][7:0]);
            end
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
        assign ram_rd[k] = rpipe[LAT-1];
    end

    int          m_ptr [2];
    int          m_own [2];
    int          m_cnt [2];
    int          m_g [2];
    bit          m_ext [2];
    bit          exp_v [2][8];
    int          exp_ch [2][8];
    logic [15:0] exp_d [2][8];
    logic [15:0] ref_mem [2][256];
    bit          ref_wr [2][256];
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [2:0]  obs_gnt [2];
    logic [2:0]  obs_st [2];
    logic [2:0]  obs_rv [2];
    logic        obs_we [2];
    logic [15:0] obs_addr [2];
    logic [15:0] obs_rd [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input int k, input logic [7:0] a);
        return ref_wr[k][a] ? ref_mem[k][a] : init_val(a);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_own[k] = -1; m_cnt[k] = 0; m_g[k] = -1; m_ext[k] = 1'b0;
            for (int s = 0; s < 8; s++) exp_v[k][s] = 1'b0;
            for (int a = 0; a < 256; a++) ref_wr[k][a] = 1'b0;
        end
    endtask

    // Decide this cycle's winner from the lock/priority rules.
    task automatic model_arb(input int k);
        int g;
        g = -1;
        m_ext[k] = 1'b0;
        if (m_own[k] >= 0 && rv[m_own[k]] && m_cnt[k] < ML) begin
            g = m_own[k];
            m_ext[k] = 1'b1;
        end else begin
            for (int j = 0; j < NCH; j++) begin
                int c;
                c = (k == 0) ? (m_ptr[k] + j) % NCH : j;
                if (g < 0 && rv[c]) g = c;
            end
        end
        m_g[k] = g;
    endtask

    task automatic check_comb(input int k);
        logic [2:0]  eg;
        logic        ew;
        logic [15:0] ea, ed;
        eg = '0; ew = 1'b0; ea = '0; ed = '0;
        if (m_g[k] >= 0) begin
            eg = 3'(1 << m_g[k]);
            ew = rw[m_g[k]];
            ea = ra[m_g[k]];
            ed = rd[m_g[k]];
        end
        check($sformatf("grant[%0d]", k), 32'(gnt[k]), 32'(eg));
        check($sformatf("stall[%0d]", k), 32'(stall[k]), 32'(rv & ~eg));
        check($sformatf("ram_en[%0d]", k), 32'(ram_en[k]), 32'(m_g[k] >= 0));
        check($sformatf("ram_we[%0d]", k), 32'(ram_we[k]), 32'(ew));
        check($sformatf("ram_addr[%0d]", k), 32'(ram_addr[k]), 32'(ea));
        check($sformatf("ram_wdata[%0d]", k), 32'(ram_wd[k]), 32'(ed));
        obs_gnt[k] = gnt[k]; obs_st[k] = stall[k]; obs_we[k] = ram_we[k]; obs_addr[k] = ram_addr[k];
    endtask

    task automatic model_update(input int k);
        int g, s;
        g = m_g[k];
        if (g < 0) begin
            m_own[k] = -1; m_cnt[k] = 0;
        end else begin
            if (!m_ext[k]) m_ptr[k] = (g + 1) % NCH;
            if (rl[g]) begin
                m_cnt[k] = m_ext[k] ? ((m_cnt[k] < ML) ? m_cnt[k] + 1 : ML) : 0;
                m_own[k] = g;
            end else begin
                m_own[k] = -1; m_cnt[k] = 0;
            end
            if (rw[g]) begin
                ref_mem[k][ra[g][7:0]] = rd[g];
                ref_wr[k][ra[g][7:0]]  = 1'b1;
            end else begin
                s = (cyc + LAT) % 8;
                exp_v[k][s]  = 1'b1;
                exp_ch[k][s] = g;
                exp_d[k][s]  = ref_read(k, ra[g][7:0]);
            end
        end
    endtask

    task automatic check_resp(input int k);
        int s;
        logic [2:0] em;
        s  = cyc % 8;
        em = exp_v[k][s] ? 3'(1 << exp_ch[k][s]) : 3'b000;
        check($sformatf("resp_valid[%0d]", k), 32'(rvalid[k]), 32'(em));
        if (exp_v[k][s]) check($sformatf("resp_data[%0d]", k), 32'(rdata[k]), 32'(exp_d[k][s]));
        exp_v[k][s] = 1'b0;
        obs_rv[k] = rvalid[k]; obs_rd[k] = rdata[k];
    endtask

    // One clock: check combinational outputs mid-cycle, then responses just after the edge.
    task automatic step();
        @(negedge gclk);
        for (int k = 0; k < 2; k++) begin model_arb(k); check_comb(k); end
        @(posedge gclk); #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin check_resp(k); model_update(k); end
    endtask

    task automatic apply_reset(input int n);
        PowerOn = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < n; i++) begin
            @(negedge gclk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_grant[%0d]", k), 32'(gnt[k]), 32'(0));
                check($sformatf("rst_ram_en[%0d]", k), 32'(ram_en[k]), 32'(0));
                check($sformatf("rst_stall[%0d]", k), 32'(stall[k]), 32'(rv));
                check($sformatf("rst_resp_valid[%0d]", k), 32'(rvalid[k]), 32'(0));
                check($sformatf("rst_resp_data[%0d]", k), 32'(rdata[k]), 32'(0));
            end
            @(posedge gclk); #1;
            cyc++;
        end
        PowerOn = 1'b1;
    endtask

    task automatic set_req(input int c, input logic v, input logic w, input logic l,
                           input logic [15:0] a, input logic [15:0] d);
        rv[c] = v; rw[c] = w; rl[c] = l; ra[c] = a; rd[c] = d;
    endtask

    task automatic rand_drive(input logic [2:0] acc);
        for (int c = 0; c < NCH; c++) begin
            if (!rv[c] || acc[c]) begin
                rv[c] = ($urandom_range(0, 99) < 65);
                rw[c] = ($urandom_range(0, 3) == 0);
                rl[c] = ($urandom_range(0, 3) == 0);
                ra[c] = 16'($urandom_range(0, 63));
                rd[c] = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                rv[c] = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] seen;
        logic       bad;
        logic [2:0] acc;
        n_checks = 0; n_errors = 0; cyc = 0;
        PowerOn = 1'b0; rv = '0; rw = '0; rl = '0;
        for (int c = 0; c < NCH; c++) begin ra[c] = '0; rd[c] = '0; end
        model_clear();
        @(posedge gclk); #1;

        // Reset state, with requests present so Stall must follow ReqValid.
        rv = 3'b101;
        apply_reset(3);
        rv = '0;

        // Reset in the middle of an outstanding read: nothing may come back.
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        step();
        rv = '0;
        apply_reset(2);
        seen = '0;
        repeat (4) begin step(); seen |= obs_rv[0] | obs_rv[1]; end
        check("no_resp_after_reset", 32'(seen), 32'(0));

        // All three channels read continuously.
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_rotation", 32'(obs_gnt[0]), 32'(1 << (i % 3)));
            check("fixed_ch0_wins", 32'(obs_gnt[1]), 32'(1));
        end
        rv = '0;
        repeat (LAT + 1) step();

        // Fixed priority: ch1 starves until ch0 drops.
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fixed_grant_ch0", 32'(obs_gnt[1]), 32'(1));
            check("fixed_stall_ch1", 32'(obs_st[1][1]), 32'(1));
        end
        rv[0] = 1'b0;
        step();
        check("fixed_grant_ch1", 32'(obs_gnt[1]), 32'(2));
        rv = '0;
        repeat (LAT + 1) step();

        // Lock limit: initial grant plus MAX_LOCK extensions, then ch0 once.
        apply_reset(1);
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0022, 16'h0);
        step();
        check("lock_initial_rr", 32'(obs_gnt[0]), 32'(2));
        check("lock_initial_fp", 32'(obs_gnt[1]), 32'(2));
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0);
        for (int i = 0; i < ML; i++) begin
            step();
            check("lock_ext_rr", 32'(obs_gnt[0]), 32'(2));
            check("lock_ext_fp", 32'(obs_gnt[1]), 32'(2));
        end
        step();
        check("lock_release_rr", 32'(obs_gnt[0]), 32'(1));
        check("lock_release_fp", 32'(obs_gnt[1]), 32'(1));
        repeat (4) step();
        rv = '0; rl = '0;
        repeat (LAT + 1) step();

        // Write then read-back of the same address on the next cycle.
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
        step();
        check("wr_strobe", 32'(obs_we[0]), 32'(1));
        rv = '0;
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        step();
        check("rd_no_strobe", 32'(obs_we[0]), 32'(0));
        rv = '0;
        step();
        step();
        check("raw_resp_valid", 32'(obs_rv[0]), 32'(2));
        check("raw_resp_data", 32'(obs_rd[0]), 32'(16'hBEEF));
        check("raw_resp_data_fp", 32'(obs_rd[1]), 32'(16'hBEEF));

        // ch2 requests and withdraws while ch0 holds a locked burst.
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0);
        step();
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h00EE, 16'h0);
        bad = 1'b0; seen = '0;
        repeat (2) begin
            step();
            bad |= (obs_addr[0] == 16'h00EE) | (obs_addr[1] == 16'h00EE);
        end
        rv[2] = 1'b0;
        repeat (3) begin step(); seen |= obs_rv[0] | obs_rv[1]; end
        rv = '0; rl = '0;
        repeat (LAT + 2) begin step(); seen |= obs_rv[0] | obs_rv[1]; end
        check("withdraw_addr", 32'(bad), 32'(0));
        check("withdraw_resp", 32'(seen[2]), 32'(0));

        // Randomised traffic with one reset in the middle.
        acc = '0;
        for (int i = 0; i < 600; i++) begin
            rand_drive(acc);
            step();
            acc = obs_gnt[0] & rv;
            if (i == 300) begin
                apply_reset(2);
                acc = '0;
            end
        end
        rv = '0;
        repeat (LAT + 2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one single-port synchronous RAM between pipeline requesters: IF fetch, MEM load/store, and future DMA/debug ports.
- Generalises the two-way IF/MEM bypass/stall scheme to NUM_CH channels, configurable RAM read latency, fixed or round-robin priority, and bounded lock (burst) ownership.
- Sits between the pipeline stages and the instruction/data RAM. Per-channel stall outputs feed stage stall inputs.

Parameters:
- WORD_WIDTH, 16, data width of RAM and channels.
- ADDR_WIDTH, 16, RAM address width.
- NUM_CH, 2, number of requesting channels (2..8). Channel 0 is highest fixed priority.
- RAM_LATENCY, 1, cycles from the RAM enable edge to valid RamRData (1..4).
- RR_MODE, 1, priority mode. 1 = round-robin. 0 = fixed priority, lowest index wins.
- MAX_LOCK, 4, maximum consecutive lock-extended grants to one channel (1..15).

Ports:
- gclk  in  1  system clock; all state on rising edge.
- PowerOn  in  1  asynchronous active-low reset. Low = reset.
- ReqValid  in  NUM_CH  per-channel request.
- ReqWrite  in  NUM_CH  per-channel request type. 1 = write, 0 = read.
- ReqLock  in  NUM_CH  keep ownership for the next cycle (burst).
- ReqAddr  in  NUM_CH*ADDR_WIDTH  packed addresses. Channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- ReqWData  in  NUM_CH*WORD_WIDTH  packed write data.
- ReqGrant  out  NUM_CH  one-hot or zero, combinational.
- Stall  out  NUM_CH  ReqValid & ~ReqGrant, per channel.
- RespValid  out  NUM_CH  one-cycle read-data-valid pulse, registered.
- RespData  out  WORD_WIDTH  read data, shared by all channels.
- RamEn  out  1  RAM access this cycle.
- RamWrite  out  1  RAM write strobe.
- RamAddr  out  ADDR_WIDTH  RAM address.
- RamWData  out  WORD_WIDTH  RAM write data.
- RamRData  in  WORD_WIDTH  RAM read data.

Behaviour:
- **Reset (PowerOn low, asynchronous):**
  - RR pointer = 0, lock owner = none, lock counter = 0.
  - Response pipeline cleared: RespValid = 0, RespData = 0.
  - ReqGrant, RamEn and RamWrite forced to 0. Stall = ReqValid.
- **Handshake:**
  - A request is accepted in the cycle where ReqValid[k] & ReqGrant[k] is high at the rising edge.
  - The requester holds ReqValid, ReqWrite, ReqAddr and ReqWData stable until granted.
  - Dropping ReqValid before grant withdraws the request without side effects.
- **Arbitration (combinational, same cycle):**
  - At most one grant per cycle.
  - Lock owner: if one exists, it still requests, and lock counter < MAX_LOCK, it wins regardless of priority.
  - RR_MODE = 1: otherwise the first requesting channel searching from the RR pointer upward, with wrap-around, wins.
  - RR_MODE = 0: otherwise the lowest index wins.
  - No requests: no grant, RamEn = 0.
- **RAM drive:**
  - RamEn = |ReqGrant.
  - RamWrite, RamAddr and RamWData are muxed from the granted channel.
  - When RamEn = 0, RamAddr and RamWData are 0.
- **Pointer/lock update at each edge with a grant to channel g:**
  - RR pointer = (g+1) mod NUM_CH. The pointer does not advance during lock-extended grants.
  - If ReqLock[g] is high: owner = g, counter += 1, saturating at MAX_LOCK.
  - Else: owner = none, counter = 0.
  - When counter reaches MAX_LOCK, ownership is released for one arbitration round. Normal priority applies, then owner/counter reset.
  - No grant: owner = none, counter = 0.
- **Read response:**
  - Each read grant pushes {valid, channel id} into a RAM_LATENCY-deep shift register.
  - RespValid[id] pulses exactly RAM_LATENCY cycles after the accepting edge, with RespData = RamRData registered at that edge.
  - Writes push valid = 0 and produce no response.
  - The pipeline holds at most RAM_LATENCY outstanding reads. There is no backpressure: responses cannot be refused.
- **Simultaneous events:**
  - Read-after-write to the same address on back-to-back grants returns the new data (the RAM is write-first). This is the RAM's contract and is not checked here.
  - A grant and a response to the same channel in the same cycle are legal.
- **Reset mid-operation:** in-flight responses are discarded; no RespValid appears after reset release for pre-reset requests.
- **Width rules:**
  - Channel id width = clog2(NUM_CH), minimum 1.
  - Counter width = 4 bits.

Test Plan:
- **Reset:** drive PowerOn low mid-read with NUM_CH=2, RAM_LATENCY=2 -> RespValid stays 0 for all following cycles and the RR pointer reads 0.
- **Round-robin:** NUM_CH=3, RR_MODE=1, all channels request reads continuously -> grants rotate 0,1,2,0,... and each RespValid arrives RAM_LATENCY cycles after its grant with the RAM contents at its address (addr 0x10/0x20/0x30 -> data 0xA1/0xB2/0xC3).
- **Fixed priority:** RR_MODE=0, ch0 and ch1 request -> ch0 granted every cycle, Stall[1]=1 throughout, ch1 granted on the first cycle ch0 drops.
- **Lock limit:** MAX_LOCK=4, ch1 holds ReqLock with ch0 also requesting -> ch1 gets the initial grant plus 4 lock-extended grants, then ch0 is granted once, then arbitration resumes normally.
- **Write/read mix:** ch0 writes 0xBEEF to 0x0040, then ch1 reads 0x0040 next cycle -> RamWrite=1 for one cycle, no RespValid for ch0, RespValid[1] with RespData=0xBEEF.
- **Idle and withdrawal:** ch2 raises ReqValid then drops it before grant while ch0 holds the bus -> RamEn never shows ch2's address and no response is produced for ch2.
